// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches from imem over req/gnt/rvalid,
// issues to decode and resolves branch/jump on acceptance.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      inst,
   output logic             inst_valid,
   output logic [31:0]      inst_pc,
   output logic [31:0]      inst_pc4,
   input  logic             inst_ready,
   input  logic             br_en,
   input  logic [2:0]       branch,
   input  logic             jump,
   input  logic             br_eq,
   input  logic             br_lt,
   input  logic [31:0]      alu_target,
   output logic             pc_sel,
   output logic             misalign_err,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [31:0] pc;
   logic        cond;
   logic        taken;
   logic [31:0] target;
   logic [31:0] next_pc;
   logic        misal;
   logic        accept;

   // branch condition decode from the control unit's Branch code
   always_comb begin
      cond = 1'b0;
      unique case (branch)
         3'b000:  cond = br_eq;
         3'b001:  cond = ~br_eq;
         3'b010:  cond = br_lt;
         3'b011:  cond = ~br_lt;
         3'b100:  cond = br_lt;
         3'b101:  cond = ~br_lt;
         default: cond = 1'b0;
      endcase
   end

   // redirect resolution; jump wins over a conditional branch
   always_comb begin
      taken   = jump | (br_en & cond);
      target  = jump ? {alu_target[31:1], 1'b0} : alu_target;
      next_pc = taken ? target : inst_pc4;
      misal   = taken & target[1];
      accept  = (state == ISSUE) & inst_ready;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         FETCH: if (imem_gnt)    state_nx = WAIT;
         WAIT:  if (imem_rvalid) state_nx = ISSUE;
         ISSUE: if (inst_ready)  state_nx = misal ? HALT : FETCH;
         HALT:  state_nx = HALT;
         default: state_nx = FETCH;
      endcase
   end

   // outputs; request is masked while reset is asserted
   always_comb begin
      imem_req   = (state == FETCH) & rst_n;
      inst_valid = (state == ISSUE);
      pc_sel     = inst_valid & inst_ready & taken;
      imem_addr  = pc;
      inst_pc4   = inst_pc + 32'd4;
   end

   // PC, instruction latch, retire counter and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         inst         <= 32'h0;
         inst_pc      <= RESET_PC;
         misalign_err <= 1'b0;
         instret      <= '0;
      end else begin
         if ((state == WAIT) && imem_rvalid) begin
            inst    <= imem_rdata;
            inst_pc <= pc;
         end
         if (accept) begin
            instret <= instret + CNT_W'(1);
            if (misal) misalign_err <= 1'b1;
            else       pc <= next_pc;
         end
      end
   end

endmodule
